// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_pkg
//  Description : Shared core constants and types for the fetch front end:
//                default address width, instruction width, the canonical
//                NOP encoding and the fetch-queue FSM state type.
//  Revision    : 1.0  initial release
// ============================================================================
package core_pkg;

    localparam int c_xlen_default = 64;
    localparam int c_ilen         = 32;

    // addi x0, x0, 0
    localparam logic [c_ilen-1:0] c_nop_inst = 32'h0000_0013;

    // FETCH: no stale responses pending. DRAIN: stale responses still in flight.
    typedef enum logic [0:0] {
        FQ_FETCH = 1'b0,
        FQ_DRAIN = 1'b1
    } fq_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : DEPTH-entry FIFO of {PC, instruction} pairs between the
//                instruction memory response path and decode.
//                Ports:
//                  clk, rst        clock, asynchronous active-high reset
//                  flush           drop all entries (wins over push/pop)
//                  push, push_pc, push_inst   write at tail
//                  pop             advance head
//                  head_pc, head_inst         head entry (0 / NOP when empty)
//                  full, empty, count         occupancy status
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_fifo
    import core_pkg::*;
#(
    parameter int XLEN  = c_xlen_default,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [XLEN-1:0]        push_pc,
    input  logic [c_ilen-1:0]      push_inst,
    input  logic                   pop,
    output logic [XLEN-1:0]        head_pc,
    output logic [c_ilen-1:0]      head_inst,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0]   r_pc_mem   [DEPTH];
    logic [c_ilen-1:0] r_inst_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    logic w_do_push;
    logic w_do_pop;

    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;

    // Push into a full FIFO is allowed only when the head leaves the same cycle.
    assign w_do_push = push & (~full | pop) & ~flush;
    assign w_do_pop  = pop & ~empty & ~flush;

    // DEPTH is a power of two, so pointer wrap is the natural AW-bit overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_pc_mem[r_wr_ptr]   <= push_pc;
            r_inst_mem[r_wr_ptr] <= push_inst;
        end
    end

    assign head_pc   = empty ? '0         : r_pc_mem[r_rd_ptr];
    assign head_inst = empty ? c_nop_inst : r_inst_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Instruction fetch front end. Issues sequential fetch
//                requests under a credit limit, buffers in-order responses
//                with their PCs, and discards stale responses after a
//                redirect.
//                Ports:
//                  clk, rst                 clock, asynchronous active-high reset
//                  redirect, redirect_pc    control transfer: flush and refetch
//                  im_req, im_addr, im_gnt  instruction memory request handshake
//                  im_rvalid, im_rdata      in-order instruction responses
//                  dec_valid, dec_inst, dec_pc, dec_ready   decode interface
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_queue
    import core_pkg::*;
#(
    parameter int              XLEN     = c_xlen_default,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              im_req,
    output logic [XLEN-1:0]   im_addr,
    input  logic              im_gnt,
    input  logic              im_rvalid,
    input  logic [c_ilen-1:0] im_rdata,
    output logic              dec_valid,
    output logic [c_ilen-1:0] dec_inst,
    output logic [XLEN-1:0]   dec_pc,
    input  logic              dec_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    fq_state_e       r_state;
    logic [XLEN-1:0] r_pc;          // next fetch address
    logic [XLEN-1:0] r_resp_pc;     // PC of the next non-stale response
    logic [CW-1:0]   r_outstanding; // live requests awaiting response
    logic [CW-1:0]   r_discard;     // stale requests awaiting response

    logic [CW-1:0]   w_count;
    logic            w_full;
    logic            w_empty;
    logic [CW-1:0]   w_inflight;
    logic [CW-1:0]   w_credit_used;
    logic [CW-1:0]   w_discard_redirect;
    logic [XLEN-1:0] w_target;
    logic            w_accept;
    logic            w_live_rsp;
    logic            w_drop;
    logic            w_push;
    logic            w_pop;

    // Stale requests still occupy memory slots, so they consume credit too.
    assign w_inflight    = r_outstanding + r_discard;
    assign w_credit_used = w_inflight + w_count;

    assign im_req   = ~rst & ~redirect & (w_credit_used < CW'(DEPTH));
    assign im_addr  = r_pc;
    assign w_accept = im_req & im_gnt;

    // In FETCH every response is live; in DRAIN the oldest ones are stale.
    assign w_live_rsp = im_rvalid & (r_state == FQ_FETCH);
    assign w_drop     = im_rvalid & (r_state == FQ_DRAIN);

    assign w_push = w_live_rsp & ~redirect & (~w_full | w_pop);
    assign w_pop  = dec_valid & dec_ready & ~redirect;

    assign w_target = redirect_pc & ~XLEN'(3);

    // Everything in flight becomes stale; a response arriving this very
    // cycle retires one of them, whichever kind it was.
    assign w_discard_redirect = w_inflight - CW'(im_rvalid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= FQ_FETCH;
            r_pc          <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else if (redirect) begin
            r_pc          <= w_target;
            r_resp_pc     <= w_target;
            r_outstanding <= '0;
            r_discard     <= w_discard_redirect;
            r_state       <= (w_discard_redirect != '0) ? FQ_DRAIN : FQ_FETCH;
        end else begin
            if (w_accept) r_pc      <= r_pc + XLEN'(4);
            if (w_push)   r_resp_pc <= r_resp_pc + XLEN'(4);
            r_outstanding <= r_outstanding + CW'(w_accept) - CW'(w_live_rsp);
            r_discard     <= r_discard - CW'(w_drop);
            case (r_state)
                FQ_FETCH: r_state <= FQ_FETCH;
                FQ_DRAIN: if (w_drop && (r_discard == CW'(1))) r_state <= FQ_FETCH;
                default:  r_state <= FQ_FETCH;
            endcase
        end
    end

    fetch_fifo #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (w_push),
        .push_pc   (r_resp_pc),
        .push_inst (im_rdata),
        .pop       (w_pop),
        .head_pc   (dec_pc),
        .head_inst (dec_inst),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    assign dec_valid = ~w_empty;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_queue
//  Description : Self-checking bench for fetch_queue. A queue-based model of
//                the memory (in-order, tagged stale on redirect) and of the
//                decode buffer predicts every output each cycle; directed
//                phases pin the model with literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_queue;

    localparam int          XLEN   = 64;
    localparam int          DEPTH  = 4;
    localparam logic [63:0] RST_PC = 64'h0;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        im_req;
    logic [63:0] im_addr;
    logic        im_gnt = 1'b0;
    logic        im_rvalid = 1'b0;
    logic [31:0] im_rdata = '0;
    logic        dec_valid;
    logic [31:0] dec_inst;
    logic [63:0] dec_pc;
    logic        dec_ready = 1'b0;

    fetch_queue #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (RST_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .im_req      (im_req),
        .im_addr     (im_addr),
        .im_gnt      (im_gnt),
        .im_rvalid   (im_rvalid),
        .im_rdata    (im_rdata),
        .dec_valid   (dec_valid),
        .dec_inst    (dec_inst),
        .dec_pc      (dec_pc),
        .dec_ready   (dec_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] data;
        int          ready;
        bit          stale;
    } mem_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } ent_t;

    mem_t        mem_q[$];   // requests accepted by memory, oldest first
    ent_t        dq[$];      // decode buffer contents, head first
    logic [63:0] m_pc = RST_PC;
    int          cyc = 0;
    int          ps = 0;

    int n_pass  = 0;
    int n_total = 0;

    int lat_min = 1, lat_max = 1;
    int p_gnt = 100, p_rv = 100, p_rdy = 100, p_redir = 0;
    bit          force_redir = 1'b0;
    logic [63:0] force_pc = '0;

    logic [63:0] pop_pc[$];
    int          pop_at[$];
    logic        samp_req[$];
    logic [63:0] samp_addr[$];
    logic        samp_valid[$];
    logic [31:0] samp_inst[$];

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_5A5A;
    endfunction

    function automatic bit model_req();
        return ((mem_q.size() + dq.size()) < DEPTH) && !redirect;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic clear_logs();
        pop_pc.delete();
        pop_at.delete();
        samp_req.delete();
        samp_addr.delete();
        samp_valid.delete();
        samp_inst.delete();
        ps = 0;
    endtask

    task automatic compare();
        bit exp_valid;
        exp_valid = (dq.size() > 0);
        check("im_req",    im_req,    model_req());
        check("im_addr",   im_addr,   m_pc);
        check("dec_valid", dec_valid, exp_valid);
        check("dec_pc",    dec_pc,    exp_valid ? dq[0].pc : 64'h0);
        check("dec_inst",  dec_inst,  exp_valid ? dq[0].inst : NOP);
    endtask

    task automatic step();
        mem_t r;
        bit   req;
        bit   rsp;
        @(negedge clk);
        redirect = force_redir || ($urandom_range(99) < p_redir);
        if (force_redir)                  redirect_pc = force_pc;
        else if ($urandom_range(3) == 0)  redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
        else                              redirect_pc = {$urandom, $urandom};
        im_gnt    = ($urandom_range(99) < p_gnt);
        dec_ready = ($urandom_range(99) < p_rdy);
        if (mem_q.size() > 0 && mem_q[0].ready <= cyc && $urandom_range(99) < p_rv) begin
            im_rvalid = 1'b1;
            im_rdata  = mem_q[0].data;
        end else begin
            im_rvalid = 1'b0;
            im_rdata  = $urandom;
        end
        #1;
        compare();
        req = model_req();
        rsp = im_rvalid;
        samp_req.push_back(im_req);
        samp_addr.push_back(im_addr);
        samp_valid.push_back(dec_valid);
        samp_inst.push_back(dec_inst);
        if (dec_valid && dec_ready && !redirect) begin
            pop_pc.push_back(dec_pc);
            pop_at.push_back(ps);
        end
        @(posedge clk);
        r = '{pc: '0, data: '0, ready: 0, stale: 1'b1};
        if (rsp) r = mem_q.pop_front();
        if (redirect) begin
            dq.delete();
            foreach (mem_q[i]) mem_q[i].stale = 1'b1;
            m_pc = redirect_pc & ~64'h3;
        end else begin
            if (dq.size() > 0 && dec_ready) void'(dq.pop_front());
            if (rsp && !r.stale) dq.push_back('{pc: r.pc, inst: r.data});
            if (req && im_gnt) begin
                mem_q.push_back('{pc: m_pc, data: mem_word(m_pc),
                                  ready: cyc + 1 + int'($urandom_range(lat_max, lat_min)) - 1,
                                  stale: 1'b0});
                m_pc = m_pc + 64'd4;
            end
        end
        ps++;
        cyc++;
    endtask

    // Asynchronous reset asserted between clock edges; memory resets with it.
    task automatic async_reset();
        @(negedge clk);
        #2;
        rst       = 1'b1;
        redirect  = 1'b0;
        im_gnt    = 1'b0;
        im_rvalid = 1'b0;
        #1;
        check("rst_imm_im_req",    im_req,    1'b0);
        check("rst_imm_dec_valid", dec_valid, 1'b0);
        mem_q.delete();
        dq.delete();
        m_pc = RST_PC;
        repeat (2) @(negedge clk);
        check("rst_im_addr",  im_addr,  RST_PC);
        check("rst_dec_inst", dec_inst, NOP);
        check("rst_dec_pc",   dec_pc,   64'h0);
        check("rst_im_req",   im_req,   1'b0);
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("reset_im_req",    im_req,    1'b0);
        check("reset_im_addr",   im_addr,   RST_PC);
        check("reset_dec_valid", dec_valid, 1'b0);
        check("reset_dec_inst",  dec_inst,  NOP);
        check("reset_dec_pc",    dec_pc,    64'h0);
        rst = 1'b0;

        // Streaming: grant always, latency 1, decode always ready
        lat_min = 1; lat_max = 1; p_gnt = 100; p_rv = 100; p_rdy = 100; p_redir = 0;
        clear_logs();
        repeat (8) step();
        check("stream_first_req",  samp_req[0],  1'b1);
        check("stream_first_addr", samp_addr[0], RST_PC);
        check("stream_npops", (pop_pc.size() >= 3), 1'b1);
        if (pop_pc.size() >= 3) begin
            check("stream_pop0_pc", pop_pc[0], 64'h0);
            check("stream_pop1_pc", pop_pc[1], 64'h4);
            check("stream_pop2_pc", pop_pc[2], 64'h8);
            check("stream_pop0_at", 64'(pop_at[0]), 64'd2);
            check("stream_pop2_at", 64'(pop_at[2]), 64'd4);
        end

        // Decode stall fills the queue, fetch stops; release drains in order
        p_rdy = 0;
        clear_logs();
        repeat (10) step();
        check("stall_im_req",    samp_req[9],   1'b0);
        check("stall_dec_valid", samp_valid[9], 1'b1);
        p_rdy = 100; p_gnt = 0;
        clear_logs();
        repeat (8) step();
        check("release_npops", 64'(pop_pc.size()), 64'd4);
        if (pop_pc.size() == 4) begin
            for (int i = 1; i < 4; i++)
                check("release_order", pop_pc[i], pop_pc[i-1] + 64'd4);
        end

        // Redirect in the same cycle as a pop of a full queue
        p_rdy = 0; p_gnt = 100;
        repeat (8) step();
        force_redir = 1'b1; force_pc = 64'h2000; p_rdy = 100;
        clear_logs();
        step();
        force_redir = 1'b0;
        step();
        check("redir_full_valid", samp_valid[1], 1'b0);
        check("redir_full_inst",  samp_inst[1],  NOP);
        check("redir_full_addr",  samp_addr[1],  64'h2000);

        // Latency 3, three outstanding, redirect to misaligned 0x1002
        async_reset();
        lat_min = 3; lat_max = 3; p_gnt = 100; p_rv = 100; p_rdy = 100;
        clear_logs();
        repeat (3) step();
        force_redir = 1'b1; force_pc = 64'h1002;
        step();
        force_redir = 1'b0;
        repeat (20) step();
        check("drain_first_addr", samp_addr[0], RST_PC);
        check("drain_new_addr",   samp_addr[4], 64'h1000);
        check("drain_any_pop", (pop_pc.size() > 0), 1'b1);
        if (pop_pc.size() > 0) check("drain_first_pop", pop_pc[0], 64'h1000);

        // Second redirect while still draining stale responses
        async_reset();
        clear_logs();
        repeat (3) step();
        force_redir = 1'b1; force_pc = 64'h1000;
        step();
        force_redir = 1'b0;
        step();
        force_redir = 1'b1; force_pc = 64'h3000;
        step();
        force_redir = 1'b0;
        repeat (20) step();
        check("redrain_any_pop", (pop_pc.size() > 0), 1'b1);
        if (pop_pc.size() > 0) check("redrain_first_pop", pop_pc[0], 64'h3000);

        // Randomized traffic with a mid-stream asynchronous reset
        lat_min = 1; lat_max = 4; p_gnt = 70; p_rv = 70; p_rdy = 70; p_redir = 4;
        repeat (1500) step();
        async_reset();
        repeat (1500) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
